// File: rtl/alu_core.sv
// alu_core: 32-bit, eight-operation ALU with a single registered output stage.
// Operands and opcode are captured on the rising clock edge when in_valid is
// high. The result, zero and overflow flags appear one cycle later alongside a
// one-cycle out_valid pulse. Cycles without in_valid leave the result
// registers holding their previous values.

module alu_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  ALU_Ctr,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [4:0]  shamt,
   input  logic        in_valid,
   output logic [31:0] res,
   output logic        zero,
   output logic        overflow,
   output logic        out_valid
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic [31:0] sum;
   logic [31:0] diff;
   logic        add_ovf;
   logic        sub_ovf;
   logic        slt_bit;
   logic [31:0] alu_res;
   logic        alu_ovf;

   logic [31:0] res_q, res_d;
   logic        zero_q, zero_d;
   logic        ovf_q, ovf_d;
   logic        out_valid_q, out_valid_d;

   assign sum  = A + B;
   assign diff = A - B;

   assign add_ovf = (A[31] == B[31]) && (sum[31] != A[31]);
   assign sub_ovf = (A[31] != B[31]) && (diff[31] != A[31]);

   // The sign of A-B is wrong exactly when the subtraction overflows.
   // Flipping it in that case gives a correct signed less-than result.
   assign slt_bit = diff[31] ^ sub_ovf;

   // Decode the opcode and select the operation result and its overflow flag.
   always_comb begin
      alu_res = 32'h0;
      alu_ovf = 1'b0;
      case (ALU_Ctr)
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = add_ovf;
         end
         OP_XOR: alu_res = A ^ B;
         OP_NOR: alu_res = ~(A | B);
         OP_SLL: alu_res = B << shamt;
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = sub_ovf;
         end
         OP_SLT: alu_res = {31'h0, slt_bit};
         default: alu_res = 32'h0;
      endcase
   end

   // Load a new result on an accepted operation; otherwise hold the old one.
   always_comb begin
      res_d       = res_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         res_d  = alu_res;
         zero_d = (alu_res == 32'h0);
         ovf_d  = alu_ovf;
      end
   end

   // Output registers. Reset shows a zero result with its zero flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q       <= 32'h0;
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         res_q       <= res_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign res       = res_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and random checks of alu_core using a scoreboard of
// expected results, pushed at drive time and popped when out_valid appears.

module tb_alu_core;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  ALU_Ctr = 3'b000;
   logic [31:0] A = 32'h0;
   logic [31:0] B = 32'h0;
   logic [4:0]  shamt = 5'h0;
   logic        in_valid = 1'b0;
   logic [31:0] res;
   logic        zero;
   logic        overflow;
   logic        out_valid;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;
   int   checks = 0;
   int   errors = 0;

   alu_core dut (
      .clk       (clk),
      .rst       (rst),
      .ALU_Ctr   (ALU_Ctr),
      .A         (A),
      .B         (B),
      .shamt     (shamt),
      .in_valid  (in_valid),
      .res       (res),
      .zero      (zero),
      .overflow  (overflow),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Reference model: uses wide signed arithmetic for overflow and native
   // signed compare for SLT.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh);
      exp_t   e;
      longint sa;
      longint sb_v;
      longint w;
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      e.ovf = 1'b0;
      case (op)
         3'b000: e.res = a & b;
         3'b001: e.res = a | b;
         3'b010: begin
            w     = sa + sb_v;
            e.res = w[31:0];
            e.ovf = (w > 64'sd2147483647) || (w < -64'sd2147483648);
         end
         3'b011: e.res = a ^ b;
         3'b100: e.res = ~(a | b);
         3'b101: e.res = b << sh;
         3'b110: begin
            w     = sa - sb_v;
            e.res = w[31:0];
            e.ovf = (w > 64'sd2147483647) || (w < -64'sd2147483648);
         end
         default: e.res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      endcase
      e.zero = (e.res == 32'h0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock: sample outputs 1 time unit after the rising edge, then
   // return at the following falling edge ready for the next drive.
   task automatic cycle(input logic v);
      exp_t e;
      @(posedge clk);
      #1;
      chk("out_valid", {31'h0, out_valid}, {31'h0, v});
      if (v) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: observed empty queue expected an entry");
         end else begin
            e = sb.pop_front();
            last_exp = e;
         end
      end
      chk("res", res, last_exp.res);
      chk("zero", {31'h0, zero}, {31'h0, last_exp.zero});
      chk("overflow", {31'h0, overflow}, {31'h0, last_exp.ovf});
      @(negedge clk);
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      ALU_Ctr  = op;
      A        = a;
      B        = b;
      shamt    = sh;
      in_valid = 1'b1;
   endtask

   task automatic op_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] r, input logic z,
                         input logic o);
      exp_t e;
      drive(op, a, b, sh);
      e.res  = r;
      e.zero = z;
      e.ovf  = o;
      sb.push_back(e);
      cycle(1'b1);
   endtask

   task automatic op_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
      drive(op, a, b, sh);
      sb.push_back(model(op, a, b, sh));
      cycle(1'b1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      A        = $urandom;
      B        = $urandom;
      ALU_Ctr  = 3'($urandom_range(0, 7));
      shamt    = 5'($urandom_range(0, 31));
      cycle(1'b0);
   endtask

   initial begin
      last_exp.res  = 32'h0;
      last_exp.zero = 1'b1;
      last_exp.ovf  = 1'b0;

      // Reset with an operation presented: it must be discarded.
      rst = 1'b1;
      drive(3'b001, 32'hffff0000, 32'h0000ffff, 5'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_res", res, 32'h0);
      chk("rst_zero", {31'h0, zero}, 32'h1);
      chk("rst_ovf", {31'h0, overflow}, 32'h0);
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      rst = 1'b0;
      idle();

      // Back-to-back sequence on alternating-bit operands.
      op_exp(3'b111, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd0, 32'h00000001, 1'b0, 1'b0);
      op_exp(3'b110, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd0, 32'h4b4b4b4b, 1'b0, 1'b1);
      op_exp(3'b101, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd9, 32'hb4b4b400, 1'b0, 1'b0);
      op_exp(3'b100, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd0, 32'h00000000, 1'b1, 1'b0);
      op_exp(3'b011, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd0, 32'hffffffff, 1'b0, 1'b0);
      op_exp(3'b010, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd0, 32'hffffffff, 1'b0, 1'b0);
      op_exp(3'b001, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd0, 32'hffffffff, 1'b0, 1'b0);
      op_exp(3'b000, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd0, 32'h00000000, 1'b1, 1'b0);

      op_exp(3'b111, 32'h01234567, 32'h76543210, 5'd0, 32'h00000001, 1'b0, 1'b0);
      op_exp(3'b010, 32'h01234567, 32'h76543210, 5'd0, 32'h77777777, 1'b0, 1'b0);

      // Overflow edges, and an SLT whose subtraction overflows.
      op_exp(3'b010, 32'h7fffffff, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1);
      op_exp(3'b110, 32'h80000000, 32'h00000001, 5'd0, 32'h7fffffff, 1'b0, 1'b1);
      op_exp(3'b111, 32'h80000000, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0);
      op_exp(3'b111, 32'h7fffffff, 32'hffffffff, 5'd0, 32'h00000000, 1'b1, 1'b0);

      // Shift boundaries, plus a non-shift op with a non-zero shamt.
      op_exp(3'b101, 32'h12345678, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0);
      op_exp(3'b101, 32'h12345678, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0);
      op_exp(3'b011, 32'h0000000f, 32'h000000f0, 5'd7, 32'h000000ff, 1'b0, 1'b0);

      // Idle cycles must hold the last result.
      idle();
      idle();
      idle();

      // Random operations checked against the model.
      for (int i = 0; i < 40; i++) begin
         op_model(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
         if ((i % 7) == 3) idle();
      end

      // Reset asserted between edges with an operation pending.
      drive(3'b001, 32'h00000001, 32'h00000002, 5'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_res", res, 32'h0);
      chk("async_zero", {31'h0, zero}, 32'h1);
      chk("async_ovf", {31'h0, overflow}, 32'h0);
      chk("async_valid", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      last_exp.res  = 32'h0;
      last_exp.zero = 1'b1;
      last_exp.ovf  = 1'b0;
      idle();
      idle();

      op_exp(3'b110, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1'b1, 1'b0);
      op_model(3'b010, 32'h80000000, 32'h80000000, 5'd0);
      idle();

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
